// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: turns EX/MEM load/store strobes into a req/ack transaction
// on a multi-cycle data memory, stalling the pipeline until completion or abort.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             access;
  logic             aligned;
  logic             tmo_hit;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (addr_i[1:0] == 2'b00);
  assign tmo_hit = (cnt_q == TMO_LAST);

  // Memory-side strobes come straight from flops so they cannot glitch.
  assign mem_req_o = (state_q == WAIT);
  assign mem_we_o  = (state_q == WAIT) & we_q;
  assign done_o    = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_o = 1'b1;
          state_d = aligned ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_ack_i || tmo_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst_i) stall_o = 1'b0;
  end

  // Latched request fields, wait counter, read data and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              mem_addr_o  <= addr_i;
              mem_wdata_o <= wdata_i;
              we_q        <= MemWrite_i;
              cnt_q       <= '0;
            end else begin
              err_o   <= 1'b1;
              rdata_o <= '0;
            end
          end
        end
        WAIT: begin
          // Ack takes priority over a coincident timeout.
          if (mem_ack_i) begin
            if (!we_q) rdata_o <= mem_rdata_i;
          end else if (tmo_hit) begin
            err_o   <= 1'b1;
            rdata_o <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized transactions,
// checked cycle by cycle against a transaction-level schedule model.
module tb_dmem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        done_o, err_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_err;
  logic [31:0] m_rdata;
  int          exp_reqs;
  int          req_rises = 0;
  logic        req_prev  = 1'b0;

  dmem_access_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req_o && !req_prev) req_rises++;
    req_prev = mem_req_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom;
    mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
    #1;
    check_val("i_stall", 32'(stall_o), 32'd0);
    check_val("i_req",   32'(mem_req_o), 32'd0);
    check_val("i_done",  32'(done_o), 32'd0);
    check_val("i_err",   32'(err_o), 32'(m_err));
    check_val("i_rdata", rdata_o, m_rdata);
  endtask

  // One access: k = cycle of WAIT on which memory acks (1-based); k outside 1..TMO means no ack.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int k, input logic [31:0] rdat);
    logic mis;
    logic ack_ok;
    int   n;
    mis    = (addr[1:0] != 2'b00);
    ack_ok = (k >= 1) && (k <= TMO);
    n      = mis ? 0 : (ack_ok ? k : TMO);

    @(negedge clk);
    rst_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wd;
    mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
    #1;
    check_val("t_stall", 32'(stall_o), 32'd1);
    check_val("t_req",   32'(mem_req_o), 32'd0);
    check_val("t_done",  32'(done_o), 32'd0);
    check_val("t_err",   32'(err_o), 32'(m_err));
    check_val("t_rdata", rdata_o, m_rdata);

    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      mem_ack_i   = (j == k);
      mem_rdata_i = (j == k) ? rdat : $urandom;
      #1;
      check_val("w_req",   32'(mem_req_o), 32'd1);
      check_val("w_stall", 32'(stall_o), 32'd1);
      check_val("w_we",    32'(mem_we_o), 32'(wr));
      check_val("w_addr",  mem_addr_o, addr);
      check_val("w_wdata", mem_wdata_o, wd);
      check_val("w_done",  32'(done_o), 32'd0);
    end

    if (!mis) exp_reqs++;
    if (mis || !ack_ok) begin
      m_err   = 1'b1;
      m_rdata = '0;
    end else if (!wr) begin
      m_rdata = rdat;
    end

    // DONE cycle: EX/MEM strobes still asserted, must not start a new request.
    @(negedge clk);
    mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
    #1;
    check_val("d_done",  32'(done_o), 32'd1);
    check_val("d_stall", 32'(stall_o), 32'd0);
    check_val("d_req",   32'(mem_req_o), 32'd0);
    check_val("d_rdata", rdata_o, m_rdata);
    check_val("d_err",   32'(err_o), 32'(m_err));
  endtask

  initial begin
    logic        rd, wr;
    logic [31:0] a;
    int          sel, k, gaps;

    m_err = 1'b0; m_rdata = '0; exp_reqs = 0;
    rst_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    addr_i = 32'h40; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset held two cycles with a load pending
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check_val("r_req",   32'(mem_req_o), 32'd0);
      check_val("r_we",    32'(mem_we_o), 32'd0);
      check_val("r_addr",  mem_addr_o, 32'd0);
      check_val("r_wdata", mem_wdata_o, 32'd0);
      check_val("r_rdata", rdata_o, 32'd0);
      check_val("r_done",  32'(done_o), 32'd0);
      check_val("r_err",   32'(err_o), 32'd0);
      check_val("r_stall", 32'(stall_o), 32'd0);
    end

    do_access(1'b1, 1'b0, 32'h40, 32'h0, 2, 32'hA5A5_0001);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 3, 32'hDEAD_BEEF);
    idle_cycle();
    do_access(1'b0, 1'b1, 32'h100, 32'h1234_5678, 1, 32'hFFFF_FFFF);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'h104, 32'h0, TMO, 32'h0BAD_CAFE);
    check_val("tmo_edge_err", 32'(err_o), 32'd0);
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h1111_2222);
    do_access(1'b1, 1'b1, 32'h204, 32'h5555_AAAA, 2, 32'h3333_4444);
    do_access(1'b1, 1'b0, 32'h208, 32'h0, 1, 32'h7777_8888);

    // Reset in the middle of WAIT
    @(negedge clk);
    rst_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h300; mem_ack_i = 1'b0;
    #1; check_val("mr_t_stall", 32'(stall_o), 32'd1);
    @(negedge clk); #1; check_val("mr_w_req", 32'(mem_req_o), 32'd1);
    exp_reqs++;
    @(negedge clk); rst_i = 1'b0; #1;
    check_val("mr_stall_lo", 32'(stall_o), 32'd0);
    @(negedge clk); #1;
    check_val("mr_req",  32'(mem_req_o), 32'd0);
    check_val("mr_done", 32'(done_o), 32'd0);
    check_val("mr_addr", mem_addr_o, 32'd0);
    m_err = 1'b0; m_rdata = '0;
    idle_cycle();
    idle_cycle();

    do_access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h9999_9999);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h0);
    idle_cycle();

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      rd  = (sel != 1);
      wr  = (sel != 0);
      a   = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      k   = $urandom_range(0, 6);
      do_access(rd, wr, a, $urandom, k, $urandom);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idle_cycle();
    end

    idle_cycle();
    check_val("req_count", 32'(req_rises), 32'(exp_reqs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for the MEM stage of the 5-stage pipeline: converts the single-cycle MemRead/MemWrite strobes leaving the EX/MEM register into a request/acknowledge transaction on a multi-cycle data memory. It freezes the pipeline with `stall_o` until the memory acknowledges, then presents registered read data to the MEM/WB path. It also enforces a bounded wait and flags misaligned or timed-out accesses.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 255: maximum WAIT cycles before abort; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the wait counter.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  one clock; reset is synchronous and active-low.
- `MemRead_i`  in  1  load strobe from EX/MEM.
- `MemWrite_i`  in  1  store strobe from EX/MEM.
- `addr_i`  in  32  byte address (EX/MEM ALU result).
- `wdata_i`  in  32  store data (EX/MEM forwarded RT).
- `mem_req_o`  out  1  request to data memory.
- `mem_we_o`  out  1  1 = write, 0 = read; valid while `mem_req_o`.
- `mem_addr_o`  out  32  latched address.
- `mem_wdata_o`  out  32  latched store data.
- `mem_ack_i`  in  1  one-cycle completion pulse from memory.
- `mem_rdata_i`  in  32  read data, valid with `mem_ack_i`.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- `rdata_o`  out  32  read data to MEM/WB.
- `done_o`  out  1  access completes this cycle; pipeline advances at end of cycle.
- `err_o`  out  1  sticky error flag (misaligned or timeout).

## Operation

- States: IDLE, WAIT, DONE.
- `access` = `MemRead_i | MemWrite_i`. Both high: treated as write.
- IDLE, no access: stay; `stall_o`=0.
- IDLE, access, `addr_i[1:0]`==0: latch addr, wdata, we (=`MemWrite_i`); clear wait counter; -> WAIT. `stall_o`=1 combinationally in this cycle.
- IDLE, access, `addr_i[1:0]`!=0: no memory request; set `err_o`; `rdata_o`<=0; -> DONE. `stall_o`=1 this cycle.
- WAIT: `mem_req_o`=1, `stall_o`=1; address/data/we held stable throughout.
  - `mem_ack_i`=1: `rdata_o`<=`mem_rdata_i` if read (unchanged if write); -> DONE.
  - else counter+1; when counter reaches TIMEOUT_CYC-1 without ack: set `err_o`, `rdata_o`<=0, -> DONE (abort).
  - Ack and timeout in same cycle: ack wins, no error.
- DONE: `mem_req_o`=0, `stall_o`=0, `done_o`=1; EX/MEM inputs ignored (still hold the completing instruction); -> IDLE unconditionally.
- `mem_ack_i` outside WAIT: ignored.
- `err_o` sticky; cleared only by reset.
- `mem_req_o`, `mem_we_o`, `done_o` decoded from registered state (glitch-free); `stall_o` may depend combinationally on inputs in IDLE.

## Timing

- Reset (`rst_i`=0 at a rising edge): state IDLE; `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_o`=0, `done_o`=0, `err_o`=0, counter=0. `stall_o`=0 while `rst_i` low.
- Reset mid-WAIT: request drops at the next edge; no DONE generated.
- Access detected cycle T -> `mem_req_o` high from T+1. Ack at cycle T+k (k>=1) -> DONE at T+k+1 -> IDLE at T+k+2.
- Stall cycles per aligned access = k+1; minimum 2 (k=1).
- Misaligned: stall 1 cycle (T), DONE at T+1.
- Timeout: DONE at T+TIMEOUT_CYC+1.
- Back-to-back accesses: next access detected no earlier than T+k+2.

## Test plan

- Reset: hold `rst_i`=0 two cycles with `MemRead_i`=1 -> all outputs 0, no request; release -> request at next cycle.
- Load, ack after 3 WAIT cycles, `mem_rdata_i`=0xDEADBEEF -> `stall_o` high 4 cycles, DONE one cycle later with `rdata_o`=0xDEADBEEF, `mem_we_o`=0.
- Store `addr_i`=0x100, `wdata_i`=0x12345678, ack on first WAIT cycle -> `mem_we_o`=1, address/data stable, stall exactly 2 cycles, `err_o`=0.
- Misaligned load `addr_i`=0x102 -> no `mem_req_o`, 1 stall cycle, `done_o`=1 next, `rdata_o`=0, `err_o`=1 thereafter.
- TIMEOUT_CYC=4, no ack -> `mem_req_o` high 4 cycles, abort to DONE, `err_o`=1; ack coincident with last cycle instead -> normal completion, `err_o`=0.
- Two consecutive loads with DONE-cycle inputs still asserted -> exactly two memory requests, no duplicate from DONE.
